store_buffer: RTL

//  FIFO of pending stores between the MEM-stage pipeline and DataMemory. Stores retire to the buffer
//  in one cycle; entries drain one per cycle through the shared memory port when it is free.

---
 rtl/store_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//   Holds pending stores between the MEM stage and DataMemory. A store retires
//   into the buffer in one cycle. Buffered entries drain in program order, one
//   per cycle, through the shared memory port when it is free. Loads read
//   DataMemory combinationally. If buffered stores match the load address, the
//   youngest matching store supplies the load data instead.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   mem_write        MEM-stage store request
//   mem_read         MEM-stage load request
//   addr             load/store address (low ADDR_BITS significant)
//   write_data       store data
//   read_data        load result (combinational)
//   stall            hold MEM stage; current request not accepted
//   empty            no pending stores
//   dm_write_ready   memory can accept a write this cycle
//   dm_addr          address to DataMemory
//   dm_write_enable  write strobe to DataMemory
//   dm_write_data    data to DataMemory
//   dm_read_data     DataMemory combinational read data
//
// Handshake: a store is accepted when mem_write=1 and stall=0 in the same cycle.
// A drain is accepted when dm_write_enable=1 and dm_write_ready=1. The buffer
// only asserts dm_write_enable while dm_write_ready is high.
// ----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        empty,
    input  logic        dm_write_ready,
    output logic [31:0] dm_addr,
    output logic        dm_write_enable,
    output logic [31:0] dm_write_data,
    input  logic [31:0] dm_read_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_BITS-1:0] addr_q [DEPTH];
    logic [31:0]          data_q [DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 full;
    logic                 drain;
    logic                 push;
    logic                 load;
    logic                 fwd_hit;
    logic [31:0]          fwd_data;
    logic [PW-1:0]        idx;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 unused_addr_bits;

    assign req_addr         = addr[ADDR_BITS-1:0];
    assign unused_addr_bits = ^addr[31:ADDR_BITS];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A load owns the port unless the buffer is full. When the buffer is full,
    // draining takes priority so that the pipeline can make progress.
    assign drain = !empty && dm_write_ready && (full || !mem_read);
    assign stall = (mem_write && full) || (mem_read && !mem_write && full && drain);
    assign push  = mem_write && !stall;
    assign load  = mem_read && !mem_write && !stall;

    assign dm_write_enable = drain;
    assign dm_addr         = drain ? {{(32-ADDR_BITS){1'b0}}, addr_q[head_q]} : addr;
    assign dm_write_data   = drain ? data_q[head_q] : 32'h0;

    // Walk from oldest to newest so that a later match overrides an earlier one.
    // The head being drained this cycle is still included in the search.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'h0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (load) begin
            read_data = fwd_hit ? fwd_data : dm_read_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset. Reset clears count, so stale entries are never valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[tail_q] <= req_addr;
            data_q[tail_q] <= write_data;
        end
    end
endmodule
